systolic_block_mult: RTL and testbench

Output-stationary N x N systolic multiplier. It consumes one A block and one B block produced by the matrix loader/splitter and returns the C = A x B block to the STORE stage. Operands are latched on a start handshake and fed into a PE grid as skewed streams. Result appears after a fixed latency with a one-cycle done pulse.

---
 rtl/systolic_block_mult_pkg.sv | 21 ++
 rtl/systolic_pe.sv | 46 ++++
 rtl/systolic_block_mult.sv | 133 +++++++++++++
 tb/tb_systolic_block_mult.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_block_mult_pkg.sv
// rtl/systolic_block_mult_pkg.sv - shared sizes, FSM encoding and latency for the block multiplier
package systolic_block_mult_pkg;

  localparam int N_DEF      = 2;
  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 2 * DATA_W_DEF + $clog2(N_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Skewed streams need 3N-2 steps; two extra cycles let the last products settle.
  function automatic int latency(input int n);
    return 3 * n;
  endfunction

  localparam int LAT = latency(N_DEF);

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - signed MAC processing element with registered a/b pass-through
module systolic_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           acc_d;
  logic [ACC_W-1:0]           acc_q;
  logic [DATA_W-1:0]          a_q;
  logic [DATA_W-1:0]          b_q;

  assign prod  = $signed(a_i) * $signed(b_i);
  assign acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
      a_q   <= a_i;
      b_q   <= b_i;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_block_mult.sv
// rtl/systolic_block_mult.sv - output-stationary N x N systolic block multiplier, C = A x B
module systolic_block_mult
  import systolic_block_mult_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = 2 * DATA_W + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*N*DATA_W-1:0] a_blk,
  input  logic [N*N*DATA_W-1:0] b_blk,
  output logic                  busy,
  output logic                  done,
  output logic [N*N*ACC_W-1:0]  c_blk
);

  localparam int LAT_L = latency(N);
  localparam int CNT_W = $clog2(LAT_L);

  fsm_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [N*N*DATA_W-1:0] a_q;
  logic [N*N*DATA_W-1:0] b_q;
  logic [N*N*ACC_W-1:0]  c_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  pe_clr;
  logic                  pe_en;
  logic [DATA_W-1:0]     row_feed [N];
  logic [DATA_W-1:0]     col_feed [N];
  logic [DATA_W-1:0]     a_h      [N][N+1];
  logic [DATA_W-1:0]     b_v      [N+1][N];
  logic [ACC_W-1:0]      acc_w    [N][N];
  logic [N*N*ACC_W-1:0]  acc_flat;

  // Operands are accepted in IDLE and in the single DONE cycle.
  assign pe_clr = start && (state_q != ST_FEED);
  assign pe_en  = (state_q == ST_FEED);

  // Row i carries A[i][k] at step i+k, column j carries B[k][j] at step k+j.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_feed[i] = '0;
      col_feed[i] = '0;
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CNT_W'(i + k)) begin
          row_feed[i] = a_q[(i*N+k)*DATA_W +: DATA_W];
          col_feed[i] = b_q[(k*N+i)*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_flat[(i*N+j)*ACC_W +: ACC_W] = acc_w[i][j];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    assign a_h[i][0] = row_feed[i];
    assign b_v[0][i] = col_feed[i];
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr_i(pe_clr),
        .en_i (pe_en),
        .a_i  (a_h[i][j]),
        .b_i  (b_v[i][j]),
        .a_o  (a_h[i][j+1]),
        .b_o  (b_v[i+1][j]),
        .acc_o(acc_w[i][j])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_blk;
            b_q     <= b_blk;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FEED;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FEED: begin
          if (cnt_q == CNT_W'(LAT_L - 1)) begin
            c_q     <= acc_flat;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign c_blk = c_q;

endmodule

// File: tb/tb_systolic_block_mult.sv
// tb/tb_systolic_block_mult.sv - scoreboard bench for the systolic block multiplier
module tb_systolic_block_mult;

  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int AW   = 2 * DW + $clog2(N);
  localparam int ABW  = N * N * DW;
  localparam int CW   = N * N * AW;
  localparam int LATC = 3 * N;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [ABW-1:0] a_blk;
  logic [ABW-1:0] b_blk;
  logic           busy;
  logic           done;
  logic [CW-1:0]  c_blk;

  always #5 clk = ~clk;

  systolic_block_mult #(
    .N     (N),
    .DATA_W(DW),
    .ACC_W (AW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a_blk(a_blk),
    .b_blk(b_blk),
    .busy (busy),
    .done (done),
    .c_blk(c_blk)
  );

  typedef struct {
    logic [CW-1:0] c;
    int            acc;
  } sb_t;

  sb_t           sb_q[$];
  int            errors     = 0;
  int            checks     = 0;
  int            cyc        = 0;
  int            last_acc   = -100;
  int            model_free = 0;
  int            n_acc      = 0;
  logic [CW-1:0] c_hold     = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] ref_mult(input logic [ABW-1:0] a, input logic [ABW-1:0] b);
    logic [CW-1:0] r;
    longint        s;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'($signed(a[(i*N+k)*DW +: DW])) * longint'($signed(b[(k*N+j)*DW +: DW]));
        r[(i*N+j)*AW +: AW] = s[AW-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [ABW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    logic [DW-1:0] e0, e1, e2, e3;
    e0 = DW'(x0);
    e1 = DW'(x1);
    e2 = DW'(x2);
    e3 = DW'(x3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic longint c_el(input logic [CW-1:0] c, input int idx);
    logic [AW-1:0] e;
    e = c[idx*AW +: AW];
    return longint'($signed(e));
  endfunction

  // Output monitor: done timing, result, busy window and c_blk hold behaviour.
  always @(negedge clk) begin
    logic exp_done;
    sb_t  e;
    if (!rst) begin
      exp_done = (sb_q.size() > 0) && (sb_q[0].acc + LATC == cyc);
      if (done || exp_done) check("done", CW'(done), CW'(exp_done));
      if (done && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("c_blk", c_blk, e.c);
        check("latency", CW'(cyc - e.acc), CW'(LATC));
        c_hold = e.c;
      end
      check("busy", CW'(busy), CW'(last_acc >= 0 && cyc >= last_acc && cyc < last_acc + LATC));
      check("c_hold", c_blk, c_hold);
    end
  end

  task automatic drive(input logic st, input logic [ABW-1:0] a, input logic [ABW-1:0] b);
    sb_t e;
    @(negedge clk);
    start = st;
    a_blk = a;
    b_blk = b;
    @(posedge clk);
    #1;
    if (st && cyc >= model_free) begin
      e.c   = ref_mult(a, b);
      e.acc = cyc;
      sb_q.push_back(e);
      last_acc   = cyc;
      model_free = cyc + LATC + 1;
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, a_blk, b_blk);
  endtask

  task automatic check_elems(input string tag, input longint e0, input longint e1,
                             input longint e2, input longint e3);
    check(tag, CW'(c_el(c_blk, 0)), CW'(e0));
    check(tag, CW'(c_el(c_blk, 1)), CW'(e1));
    check(tag, CW'(c_el(c_blk, 2)), CW'(e2));
    check(tag, CW'(c_el(c_blk, 3)), CW'(e3));
  endtask

  initial begin
    logic [ABW-1:0] bm;
    int             target;
    rst   = 1'b1;
    start = 1'b0;
    a_blk = '0;
    b_blk = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", CW'(busy), '0);
    check("rst_done", CW'(done), '0);
    check("rst_c", c_blk, '0);
    rst = 1'b0;
    idle(2);

    drive(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    idle(7);
    check_elems("basic", 19, 22, 43, 50);

    bm = pack4(5, -6, 7, 8);
    drive(1'b1, pack4(-1, 0, 0, -1), bm);
    idle(7);
    check_elems("neg_ident", -5, 6, -7, -8);
    drive(1'b1, pack4(1, 0, 0, 1), bm);
    idle(7);
    check_elems("ident", 5, -6, 7, 8);

    drive(1'b1, pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768));
    idle(7);
    check_elems("ext_min", 64'sd2147483648, 64'sd2147483648, 64'sd2147483648, 64'sd2147483648);
    drive(1'b1, pack4(32767, 32767, 32767, 32767), pack4(-32768, -32768, -32768, -32768));
    idle(7);
    check_elems("ext_mix", -64'sd2147418112, -64'sd2147418112, -64'sd2147418112, -64'sd2147418112);

    // Start while busy is ignored; start in the DONE cycle is taken.
    drive(1'b1, pack4(2, 0, 0, 2), pack4(1, 2, 3, 4));
    drive(1'b0, pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
    drive(1'b1, pack4(7, 7, 7, 7), pack4(3, 3, 3, 3));
    while (cyc + 1 < model_free) drive(1'b0, pack4(5, 5, 5, 5), pack4(5, 5, 5, 5));
    drive(1'b1, pack4(1, 1, 1, 1), pack4(1, 2, 3, 4));
    idle(8);
    check_elems("b2b", 4, 6, 4, 6);

    // Asynchronous reset in the middle of an operation.
    drive(1'b1, pack4(3, 1, 4, 1), pack4(5, 9, 2, 6));
    idle(2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb_q.delete();
    last_acc   = -100;
    model_free = 0;
    c_hold     = '0;
    #1;
    check("mid_rst_busy", CW'(busy), '0);
    check("mid_rst_done", CW'(done), '0);
    check("mid_rst_c", c_blk, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(8);
    drive(1'b1, pack4(3, 1, 4, 1), pack4(5, 9, 2, 6));
    idle(7);
    check_elems("post_rst", 17, 33, 22, 42);

    target = n_acc + 200;
    while (n_acc < target) drive(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    idle(8);
    check("sb_empty", CW'(sb_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
